// File: rtl/ysyx_24080014_lsu_if.sv
// Handshake and bus bundle for the load/store unit: EXU request, data-memory bus, writeback result.
// slave is the LSU view; master is the view of everything around it.
interface ysyx_24080014_lsu_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_wen;
    logic [2:0]  in_func3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic        mem_resp_ready;
    logic [31:0] mem_resp_rdata;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_read_data;
    logic        out_err;

    modport slave (
        input  in_valid, in_wen, in_func3, in_addr, in_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
        input  out_ready,
        output in_ready,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        output mem_resp_ready,
        output out_valid, out_read_data, out_err
    );

    modport master (
        output in_valid, in_wen, in_func3, in_addr, in_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata,
        output out_ready,
        input  in_ready,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
        input  mem_resp_ready,
        input  out_valid, out_read_data, out_err
    );
endinterface

// File: rtl/ysyx_24080014_lsu.sv
// Load/store unit: one outstanding op, byte/half/word formatting, response timeout.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses without touching the bus.
//
// state  | meaning
// S_IDLE | ready for a new op from EXU
// S_REQ  | bus request presented, waiting for mem_req_ready
// S_WAIT | waiting for response/ack, timeout counter running
// S_DONE | result presented to writeback, waiting for out_ready
module ysyx_24080014_lsu #(
    parameter int TIMEOUT = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ysyx_24080014_lsu_if.slave     bus
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        wen_q;
    logic [2:0]  func3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [CW-1:0] cnt;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        misaligned;
    logic        timeout_hit;
    logic [31:0] load_shifted;
    logic [15:0] load_half;
    logic [31:0] load_fmt;

    // Stores decode func3 exactly; loads use func3[1:0] for width and func3[2] for unsigned.
    always_comb begin
        misaligned = 1'b0;
        if (bus.in_wen) begin
            if (bus.in_func3 == 3'b001)
                misaligned = bus.in_addr[0];
            else if (bus.in_func3 != 3'b000)
                misaligned = (bus.in_addr[1:0] != 2'b00);
        end else begin
            if (bus.in_func3[1:0] == 2'b01)
                misaligned = bus.in_addr[0];
            else if (bus.in_func3[1:0] != 2'b00)
                misaligned = (bus.in_addr[1:0] != 2'b00);
        end
        misaligned = misaligned & TRAP_EN;
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.in_valid) state_nxt = misaligned ? S_DONE : S_REQ;
            S_REQ:  if (bus.mem_req_ready) state_nxt = S_WAIT;
            S_WAIT: if (bus.mem_resp_valid || timeout_hit) state_nxt = S_DONE;
            S_DONE: if (bus.out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        load_shifted = bus.mem_resp_rdata >> {addr_q[1:0], 3'b000};
        load_half    = addr_q[1] ? bus.mem_resp_rdata[31:16] : bus.mem_resp_rdata[15:0];
        case (func3_q)
            3'b000:  load_fmt = {{24{load_shifted[7]}}, load_shifted[7:0]};
            3'b100:  load_fmt = {24'h0, load_shifted[7:0]};
            3'b001:  load_fmt = {{16{load_half[15]}}, load_half};
            3'b101:  load_fmt = {16'h0, load_half};
            default: load_fmt = bus.mem_resp_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q   <= 1'b0;
            func3_q <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            cnt     <= '0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        wen_q   <= bus.in_wen;
                        func3_q <= bus.in_func3;
                        addr_q  <= bus.in_addr;
                        wdata_q <= bus.in_wdata;
                        if (misaligned) begin
                            err_q   <= 1'b1;
                            rdata_q <= 32'h0;
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + CW'(1);
                    // A response arriving on the last allowed cycle still completes normally.
                    if (bus.mem_resp_valid) begin
                        rdata_q <= wen_q ? 32'h0 : load_fmt;
                        err_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q <= 32'h0;
                        err_q   <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        cnt   <= '0;
                        err_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready       = (state == S_IDLE);
    assign bus.mem_req_valid  = (state == S_REQ);
    assign bus.mem_resp_ready = (state == S_WAIT);
    assign bus.out_valid      = (state == S_DONE);
    assign bus.out_read_data  = rdata_q;
    assign bus.out_err        = err_q;

    assign bus.mem_req_addr   = {addr_q[31:2], 2'b00};
    assign bus.mem_req_wen    = wen_q;

    always_comb begin
        case (func3_q)
            3'b000: begin
                bus.mem_req_wstrb = 4'b0001 << addr_q[1:0];
                bus.mem_req_wdata = {4{wdata_q[7:0]}};
            end
            3'b001: begin
                bus.mem_req_wstrb = 4'b0011 << {addr_q[1], 1'b0};
                bus.mem_req_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                bus.mem_req_wstrb = 4'hF;
                bus.mem_req_wdata = wdata_q;
            end
        endcase
        if (!wen_q)
            bus.mem_req_wstrb = 4'h0;
    end

endmodule

// File: tb/tb_ysyx_24080014_lsu.sv
// Directed plus randomized bench for ysyx_24080014_lsu against a lane-level reference model.
module tb_ysyx_24080014_lsu;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    ysyx_24080014_lsu_if bus ();

    ysyx_24080014_lsu #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: access size in bytes, aligned lane offset, per-lane strobes and data.
    task automatic model(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input bit timed_out,
                         output logic [3:0] strb, output logic [31:0] wd,
                         output logic [31:0] rd, output bit mis);
        int sz, a, off;
        logic [31:0] val, mask;
        if (wen) sz = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        else     sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        a   = int'(addr[1:0]);
        off = (a / sz) * sz;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (a % sz) != 0;
`else
        mis = 1'b0;
`endif
        for (int i = 0; i < 4; i++) begin
            strb[i] = wen && (i >= off) && (i < off + sz);
            wd[8*i +: 8] = wdata[8*(i % sz) +: 8];
        end
        if (wen || timed_out || mis) begin
            rd = 32'h0;
        end else if (sz == 4) begin
            rd = rdata;
        end else begin
            mask = (32'h1 << (8 * sz)) - 32'h1;
            val  = (rdata >> (8 * off)) & mask;
            if (!f3[2] && val[8*sz-1]) val = val | ~mask;
            rd = val;
        end
    endtask

    // resp_lat >= TO means the bus never answers in time.
    task automatic run_op(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int req_lat, input int resp_lat, input int out_lat);
        logic [3:0]  e_strb;
        logic [31:0] e_wd, e_rd;
        bit          mis, timed_out;
        int          n_wait;
        timed_out = (resp_lat >= TO);
        model(wen, f3, addr, wdata, rdata, timed_out, e_strb, e_wd, e_rd, mis);
        n_wait = timed_out ? TO : resp_lat + 1;

        chk("accept_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_wen   = wen;
        bus.in_func3 = f3;
        bus.in_addr  = addr;
        bus.in_wdata = wdata;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_wen   = 1'($urandom);
        bus.in_func3 = 3'($urandom);
        bus.in_addr  = $urandom;
        bus.in_wdata = $urandom;

        if (!mis) begin
            for (int k = 0; k <= req_lat; k++) begin
                chk("req_valid", 32'(bus.mem_req_valid), 32'd1);
                chk("req_addr", bus.mem_req_addr, {addr[31:2], 2'b00});
                chk("req_wen", 32'(bus.mem_req_wen), 32'(wen));
                chk("req_wstrb", 32'(bus.mem_req_wstrb), 32'(e_strb));
                if (wen) chk("req_wdata", bus.mem_req_wdata, e_wd);
                chk("req_in_ready", 32'(bus.in_ready), 32'd0);
                chk("req_out_valid", 32'(bus.out_valid), 32'd0);
                bus.mem_req_ready = (k == req_lat);
                @(posedge clk); @(negedge clk);
            end
            bus.mem_req_ready = 1'b0;
            for (int k = 0; k < n_wait; k++) begin
                chk("wait_resp_ready", 32'(bus.mem_resp_ready), 32'd1);
                chk("wait_req_valid", 32'(bus.mem_req_valid), 32'd0);
                chk("wait_out_valid", 32'(bus.out_valid), 32'd0);
                bus.mem_resp_valid = !timed_out && (k == resp_lat);
                bus.mem_resp_rdata = bus.mem_resp_valid ? rdata : $urandom;
                @(posedge clk); @(negedge clk);
            end
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_rdata = $urandom;
        end

        for (int k = 0; k <= out_lat; k++) begin
            chk("done_out_valid", 32'(bus.out_valid), 32'd1);
            chk("done_read_data", bus.out_read_data, e_rd);
            chk("done_err", 32'(bus.out_err), 32'(timed_out || mis));
            chk("done_req_valid", 32'(bus.mem_req_valid), 32'd0);
            chk("done_resp_ready", 32'(bus.mem_resp_ready), 32'd0);
            chk("done_in_ready", 32'(bus.in_ready), 32'd0);
            bus.out_ready = (k == out_lat);
            @(posedge clk); @(negedge clk);
        end
        bus.out_ready = 1'b0;
        chk("post_out_valid", 32'(bus.out_valid), 32'd0);
        chk("post_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_err", 32'(bus.out_err), 32'd0);
    endtask

    initial begin
        bus.in_valid       = 1'b0;
        bus.in_wen         = 1'b0;
        bus.in_func3       = 3'd0;
        bus.in_addr        = 32'h0;
        bus.in_wdata       = 32'h0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = 32'h0;
        bus.out_ready      = 1'b0;

        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rst_resp_ready", 32'(bus.mem_resp_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_err", 32'(bus.out_err), 32'd0);
        chk("rst_read_data", bus.out_read_data, 32'h0);
        chk("rst_req_addr", bus.mem_req_addr, 32'h0);
        chk("rst_req_wdata", bus.mem_req_wdata, 32'h0);
        chk("rst_req_wstrb", 32'(bus.mem_req_wstrb), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0, 0);
        run_op(1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'hBEEF_0000, 0, 0, 0);
        run_op(1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'hBEEF_0000, 0, 1, 0);
        run_op(1'b1, 3'b000, 32'h8000_0001, 32'h1234_56AB, 32'hDEAD_BEEF, 0, 0, 0);
        run_op(1'b1, 3'b001, 32'h8000_0002, 32'hCAFE_5678, 32'h0, 1, 0, 1);
        run_op(1'b1, 3'b010, 32'h1000_0010, 32'hA5A5_0F0F, 32'h0, 5, 2, 3);
        run_op(1'b0, 3'b010, 32'h2000_0000, 32'h0, 32'h1234_5678, 0, 99, 0);
        run_op(1'b0, 3'b100, 32'h2000_0001, 32'h0, 32'h0000_F100, 0, 0, 0);
        run_op(1'b0, 3'b010, 32'h2000_0004, 32'h0, 32'h7654_3210, 0, TO - 1, 0);
        run_op(1'b0, 3'b010, 32'h3000_0002, 32'h0, 32'h0BAD_F00D, 0, 0, 0);
        run_op(1'b1, 3'b001, 32'h3000_0001, 32'h0000_BEEF, 32'h0, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            run_op(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, TO), $urandom_range(0, 2));
        end

        // Reset in the middle of WAIT.
        bus.in_valid = 1'b1;
        bus.in_wen   = 1'b0;
        bus.in_func3 = 3'b010;
        bus.in_addr  = 32'h4000_0000;
        @(posedge clk); @(negedge clk);
        bus.in_valid      = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.mem_req_ready = 1'b0;
        chk("mid_wait_resp_ready", 32'(bus.mem_resp_ready), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_resp_ready", 32'(bus.mem_resp_ready), 32'd0);
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("arst_req_addr", bus.mem_req_addr, 32'h0);
        chk("arst_err", 32'(bus.out_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rel_req_valid", 32'(bus.mem_req_valid), 32'd0);

        run_op(1'b0, 3'b000, 32'h5000_0002, 32'h0, 32'h00C3_0000, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ysyx_24080014_lsu.md
Name: ysyx_24080014_lsu

Overview:
- Load/store unit between the execute stage and the data-memory bus.
- Accepts one memory op per transaction and drives a simple request/response bus.
- For loads, extracts and sign/zero-extends the addressed byte, half or word, and returns it as read_data to the writeback selector.
- For stores, generates byte strobes and lane-replicated write data, then waits for the bus acknowledge.

Parameters:
- TIMEOUT, 256: max cycles in WAIT before the op is abandoned with out_err=1. 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  EXU presents an op
- in_ready  out  1  LSU can accept an op
- in_wen  in  1  1=store, 0=load
- in_func3  in  3  RV32I funct3 (width/sign)
- in_addr  in  32  byte address
- in_wdata  in  32  store data (rs2)
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts request
- mem_req_addr  out  32  word-aligned address {in_addr[31:2],2'b00}
- mem_req_wen  out  1  store request
- mem_req_wdata  out  32  lane-replicated store data
- mem_req_wstrb  out  4  byte enables; 0 for loads
- mem_resp_valid  in  1  bus response/ack valid
- mem_resp_ready  out  1  LSU accepts response
- mem_resp_rdata  in  32  raw word read
- out_valid  out  1  result valid to writeback
- out_ready  in  1  writeback accepts result
- out_read_data  out  32  formatted load data; 0 for stores
- out_err  out  1  op timed out (or misaligned, see feature)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - in_ready=1.
  - mem_req_valid, mem_resp_ready, out_valid and out_err = 0.
  - out_read_data, mem_req_addr, mem_req_wdata and mem_req_wstrb = 0.
  - Timeout counter = 0.
- FSM states: IDLE -> REQ -> WAIT -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid, register wen/func3/addr/wdata and go to REQ.
  - in_ready is 0 in all other states.
- REQ:
  - mem_req_valid=1; request fields are held stable.
  - On mem_req_ready, go to WAIT.
- WAIT:
  - mem_resp_ready=1; counter increments each cycle.
  - On mem_resp_valid, capture the formatted result and go to DONE.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no response, set out_err=1, out_read_data=0, go to DONE.
  - If a response and the timeout coincide, the response wins.
- DONE:
  - out_valid=1; out_read_data and out_err are held.
  - On out_ready, go to IDLE and clear the counter and out_err.
- Minimum latency with zero-wait bus and writeback: accept at cycle 0, REQ at cycle 1, WAIT at cycle 2, out_valid at cycle 3.
- Store strobes and data, with o=addr[1:0]:
  - SB (000): wstrb=4'b0001<<o, wdata={4{wdata[7:0]}}.
  - SH (001): wstrb=4'b0011<<{o[1],1'b0}, wdata={2{wdata[15:0]}}.
  - SW (010) and any other func3: wstrb=4'hF, wdata=wdata.
- Load formatting, with r=mem_resp_rdata:
  - LB (000): sign-extended r byte o.
  - LBU (100): zero-extended r byte o.
  - LH (001): sign-extended r half o[1].
  - LHU (101): zero-extended r half o[1].
  - LW (010) and any other func3: r.
- Stores return out_read_data=0 after the ack.
- Without the optional feature, address bits below the access width are ignored.
- Only one op is outstanding. No new acceptance occurs until DONE completes.
- A reset mid-op abandons the op immediately: all outputs return to reset values, with no bus request left asserted.

Optional Feature:
- LSU_MISALIGN_TRAP_EN
- Defined: in IDLE, LH/LHU/SH with addr[0]=1, or LW/SW/other with addr[1:0]!=0, skip REQ/WAIT and go straight to DONE with out_err=1 and out_read_data=0. No bus transaction is issued.
- Undefined: no alignment check; behaviour is as in Behaviour.

Test Plan:
- LB addr=0x8000_0003, resp rdata=0x80FF_1234, zero-wait bus -> mem_req_addr=0x8000_0000, wstrb=0, out_read_data=0xFFFF_FF80, out_valid at cycle 3.
- LHU addr=0x8000_0002, rdata=0xBEEF_0000 -> out_read_data=0x0000_BEEF; repeat as LH -> 0xFFFF_BEEF.
- SB addr=0x8000_0001 wdata=0x1234_56AB -> wstrb=4'b0010, mem_req_wdata=0xABAB_ABAB, out_read_data=0 after ack.
- SW with mem_req_ready low 5 cycles, then out_ready low 3 cycles -> request fields stable throughout, in_ready=0, single completion only.
- TIMEOUT=4, load with no response -> out_err=1, out_read_data=0 after 4 WAIT cycles; second op then completes normally with out_err=0.
- rst_n pulsed low during WAIT -> mem_resp_ready and out_valid=0 asynchronously, in_ready=1 after release; with LSU_MISALIGN_TRAP_EN, LW addr=0x...2 -> out_err=1 and mem_req_valid never asserted.
